seq_data_checker: RTL
=====================

# seq_data_checker

Read-data checker that sits downstream of the random sequence generator in the memory test path. It consumes read beats from the memory read channel, drives the generator's enable so it advances one expected word per accepted beat, and compares each beat against the generator output. It reports pass/fail, saturating error count, sticky per-byte mismatch mask and first-error capture for the traffic controller and JTAG status registers.

## Interface
- DATA_WIDTH, 256: read data width; equals generator OUTPUT_WIDTH; multiple of 8.
- CNT_WIDTH, 32: width of word-count input and check counter.
- ERR_WIDTH, 16: width of saturating error counter.

- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  level; rising edge starts a test run.
- i_num_words  in  CNT_WIDTH  beats to check; sampled on the start edge.
- i_rd_valid  in  1  read beat valid; checker is always ready.
- i_rd_data  in  DATA_WIDTH  read beat data.
- i_exp_data  in  DATA_WIDTH  expected data; generator output.
- o_gen_start  out  1  to generator start; combinational copy of i_start.
- o_gen_enable  out  1  to generator enable; combinational.
- o_busy  out  1  state RUN.
- o_done  out  1  state DONE.
- o_pass  out  1  o_done and zero errors.
- o_check_count  out  CNT_WIDTH  beats compared.
- o_error_count  out  ERR_WIDTH  mismatching beats, saturating.
- o_err_byte_mask  out  DATA_WIDTH/8  sticky OR of per-byte mismatches.
- o_first_err_valid  out  1  first error captured.
- o_first_err_index  out  CNT_WIDTH  beat index (0-based) of first error.
- o_first_err_data  out  DATA_WIDTH  received data of first error.
- o_overrun  out  1  sticky; valid beat arrived outside RUN.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- Start edge: i_start high and its registered copy low. From any state, go to RUN. Latch i_num_words. Clear accept/check/error counters, mask, first-error, overrun and pipeline valids.
- Start edge with i_num_words = 0: go directly to DONE; o_pass=1 next cycle.
- Stage 0, combinational: accept = i_rd_valid & RUN & accept_cnt < num_words & not start edge. o_gen_enable = accept. accept_cnt increments on accept.
- Stage 1, registered: v1 = accept; per-byte mismatch vector mm1[b] = |(rd^exp) over byte b; idx1 = accept_cnt; data1 = i_rd_data.
- Stage 2, registered on v1:
  - check_count+1.
  - If |mm1: error_count+1, saturating at all-ones; mask |= mm1.
  - If no prior error: first_err_valid=1, capture idx1 and data1.
- RUN→DONE when check_count reaches num_words. All counters hold in DONE until the next start edge.
- o_overrun sets on i_rd_valid in IDLE or DONE, or in RUN with accept_cnt = num_words. Such beats do not enable the generator.
- Reset mid-run: all state cleared, IDLE; in-flight beats discarded.

## Timing
- Reset values: o_busy, o_done, o_pass, o_first_err_valid, o_overrun = 0; all counts, mask, index and data = 0.
- Generator advances the cycle after an accept, so back-to-back beats each see the correct expected word. Full throughput is 1 beat/clk.
- Beat accepted at cycle N is reflected in counters/mask at N+2. o_done asserts at N+2 for the last beat.
- o_pass is combinational from o_done and error_count==0; valid only while o_done=1.
- Start edge at cycle S: o_busy=1 and counters zero at S+1. Generator restarts on the same edge; its first word is valid at S+1. Any beat at S is not accepted.

## Test plan
- Reset, start, num_words=16, 16 back-to-back beats matching generator -> o_done at last beat+2; check_count=16, error_count=0, o_pass=1, overrun=0.
- num_words=8, beat 3 has byte 5 corrupted -> error_count=1, err_byte_mask=1<<5, first_err_index=3, first_err_data=corrupted beat, o_pass=0.
- Beats with random 0–3 idle gaps, num_words=100, plus 2 extra beats after done -> o_pass=1, check_count=100, o_overrun=1, generator enabled exactly 100 times.
- ERR_WIDTH=4, 20 all-wrong beats -> error_count saturates at 15; first_err_index=0.
- Start restart after 5 beats of a 10-beat run, then full 10-beat run -> counters restart from 0; final check_count=10, o_pass=1.
- Assert i_reset for 1 cycle mid-run with a beat in each pipeline stage -> all outputs return to reset values, IDLE; beat arriving after reset sets o_overrun.

Source files
------------

// File: rtl/seq_data_checker_if.sv
// Read-channel bundle between the memory read path / sequence generator and
// seq_data_checker.
//   rd_valid, rd_data : read beat from memory (checker is always ready)
//   exp_data          : current generator output word
//   gen_start         : generator restart, follows the checker's start input
//   gen_enable        : generator advance, one pulse per accepted beat
// master = read/generator side, slave = checker side.
interface seq_data_checker_if #(
    parameter int unsigned DATA_WIDTH = 256
);
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] exp_data;
    logic                  gen_start;
    logic                  gen_enable;

    modport master (
        output rd_valid, rd_data, exp_data,
        input  gen_start, gen_enable
    );

    modport slave (
        input  rd_valid, rd_data, exp_data,
        output gen_start, gen_enable
    );
endinterface

// File: rtl/seq_data_checker.sv
// Read-data checker for the memory test path. Accepts read beats, advances the
// sequence generator once per accepted beat and compares each beat with the
// generator word. Reports pass/fail, a saturating error count, a sticky
// per-byte mismatch mask, first-error capture and a sticky overrun flag.
// Ports:
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_start             : level; rising edge starts a run
//   i_num_words         : beats to check, sampled on the start edge
//   rd                  : read channel / generator bundle (slave side)
//   o_busy, o_done      : RUN / DONE state
//   o_pass              : done with zero errors
//   o_check_count       : beats compared
//   o_error_count       : mismatching beats, saturating
//   o_err_byte_mask     : sticky OR of per-byte mismatches
//   o_first_err_*       : first mismatching beat: valid, index, data
//   o_overrun           : valid beat arrived when none was expected
module seq_data_checker #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned ERR_WIDTH  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [CNT_WIDTH-1:0]    i_num_words,
    seq_data_checker_if.slave       rd,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_pass,
    output logic [CNT_WIDTH-1:0]    o_check_count,
    output logic [ERR_WIDTH-1:0]    o_error_count,
    output logic [DATA_WIDTH/8-1:0] o_err_byte_mask,
    output logic                    o_first_err_valid,
    output logic [CNT_WIDTH-1:0]    o_first_err_index,
    output logic [DATA_WIDTH-1:0]   o_first_err_data,
    output logic                    o_overrun
);
    localparam int unsigned NB = DATA_WIDTH / 8;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic                   start_q, start_d;
    logic [CNT_WIDTH-1:0]   num_words_q, num_words_d;
    logic [CNT_WIDTH-1:0]   accept_cnt_q, accept_cnt_d;
    logic                   v1_q, v1_d;
    logic [NB-1:0]          mm1_q, mm1_d;
    logic [CNT_WIDTH-1:0]   idx1_q, idx1_d;
    logic [DATA_WIDTH-1:0]  data1_q, data1_d;
    logic [CNT_WIDTH-1:0]   check_count_q, check_count_d;
    logic [ERR_WIDTH-1:0]   error_count_q, error_count_d;
    logic [NB-1:0]          mask_q, mask_d;
    logic                   first_valid_q, first_valid_d;
    logic [CNT_WIDTH-1:0]   first_idx_q, first_idx_d;
    logic [DATA_WIDTH-1:0]  first_data_q, first_data_d;
    logic                   overrun_q, overrun_d;

    logic start_edge;
    logic running;
    logic room;
    logic accept;
    logic last_check;

    assign start_edge = i_start & ~start_q;
    assign running    = (state_q == S_RUN);
    assign room       = (accept_cnt_q < num_words_q);
    assign accept     = rd.rd_valid & running & room & ~start_edge;
    // The stage-2 check that brings check_count up to num_words ends the run.
    assign last_check = v1_q & ((check_count_q + CNT_WIDTH'(1)) == num_words_q);

    assign rd.gen_start  = i_start;
    assign rd.gen_enable = accept;

    // State register and datapath flops
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b0;
            num_words_q   <= '0;
            accept_cnt_q  <= '0;
            v1_q          <= 1'b0;
            mm1_q         <= '0;
            idx1_q        <= '0;
            data1_q       <= '0;
            check_count_q <= '0;
            error_count_q <= '0;
            mask_q        <= '0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
            first_data_q  <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            num_words_q   <= num_words_d;
            accept_cnt_q  <= accept_cnt_d;
            v1_q          <= v1_d;
            mm1_q         <= mm1_d;
            idx1_q        <= idx1_d;
            data1_q       <= data1_d;
            check_count_q <= check_count_d;
            error_count_q <= error_count_d;
            mask_q        <= mask_d;
            first_valid_q <= first_valid_d;
            first_idx_q   <= first_idx_d;
            first_data_q  <= first_data_d;
            overrun_q     <= overrun_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (start_edge) begin
            state_d = (i_num_words == '0) ? S_DONE : S_RUN;
        end else if (running && last_check) begin
            state_d = S_DONE;
        end
    end

    // Datapath next values
    always_comb begin
        start_d       = i_start;
        num_words_d   = num_words_q;
        accept_cnt_d  = accept_cnt_q;
        check_count_d = check_count_q;
        error_count_d = error_count_q;
        mask_d        = mask_q;
        first_valid_d = first_valid_q;
        first_idx_d   = first_idx_q;
        first_data_d  = first_data_q;
        overrun_d     = overrun_q;

        // Stage 1 capture
        v1_d    = accept;
        idx1_d  = accept_cnt_q;
        data1_d = rd.rd_data;
        mm1_d   = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            mm1_d[b] = |(rd.rd_data[b*8 +: 8] ^ rd.exp_data[b*8 +: 8]);
        end

        if (accept) begin
            accept_cnt_d = accept_cnt_q + CNT_WIDTH'(1);
        end

        // accept_cnt never exceeds num_words, so !room means "all accepted"
        if (rd.rd_valid && (!running || !room)) begin
            overrun_d = 1'b1;
        end

        // Stage 2 accumulate
        if (v1_q) begin
            check_count_d = check_count_q + CNT_WIDTH'(1);
            if (|mm1_q) begin
                if (error_count_q != '1) begin
                    error_count_d = error_count_q + ERR_WIDTH'(1);
                end
                mask_d = mask_q | mm1_q;
                if (!first_valid_q) begin
                    first_valid_d = 1'b1;
                    first_idx_d   = idx1_q;
                    first_data_d  = data1_q;
                end
            end
        end

        // A start edge overrides everything, including in-flight beats
        if (start_edge) begin
            num_words_d   = i_num_words;
            accept_cnt_d  = '0;
            v1_d          = 1'b0;
            check_count_d = '0;
            error_count_d = '0;
            mask_d        = '0;
            first_valid_d = 1'b0;
            first_idx_d   = '0;
            first_data_d  = '0;
            overrun_d     = 1'b0;
        end
    end

    // State-decoded outputs
    always_comb begin
        o_busy = (state_q == S_RUN);
        o_done = (state_q == S_DONE);
        o_pass = (state_q == S_DONE) && (error_count_q == '0);
    end

    assign o_check_count     = check_count_q;
    assign o_error_count     = error_count_q;
    assign o_err_byte_mask   = mask_q;
    assign o_first_err_valid = first_valid_q;
    assign o_first_err_index = first_idx_q;
    assign o_first_err_data  = first_data_q;
    assign o_overrun         = overrun_q;
endmodule
